// File: rtl/sd_sched_pkg.sv
// Shared types and constants for the Sudoku job scheduler.
package sd_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FEED,
        ST_WAIT,
        ST_DRAIN
    } sd_state_e;

    localparam logic [3:0] SD_FAIL_CODE = 4'd10;
    localparam int         SD_CELLS     = 81;
    localparam int         SD_ANS_LEN   = 15;

endpackage

// File: rtl/sd_rr_arb.sv
// Combinational round-robin select: the search starts one past the last
// winner (i_ptr) and wraps, so the previous winner has the lowest priority.
module sd_rr_arb #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_win,
    output logic [IW-1:0]      o_idx,
    output logic               o_any
);

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        o_win = '0;
        o_idx = '0;
        o_any = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (j == (int'(i_ptr) + k) % NUM_REQ && i_req[j]) begin
                    o_win    = '0;
                    o_win[j] = 1'b1;
                    o_idx    = IW'(j);
                    o_any    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sd_job_sched.sv
// Shares one Sudoku solver between NUM_REQ puzzle sources: round-robin
// grant, 81-cell forward, answer/fail burst routed back to the winner.
// Optional build macro SD_SCHED_TIMEOUT_EN adds an answer-wait watchdog
// and a DRAIN state that absorbs the solver's late burst.
module sd_job_sched
    import sd_sched_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int CELLS   = SD_CELLS,
    parameter int ANS_LEN = SD_ANS_LEN,
    parameter int TO_W    = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    output logic [NUM_REQ-1:0]     gnt,
    input  logic [NUM_REQ-1:0]     src_valid,
    input  logic [4*NUM_REQ-1:0]   src_data,
    output logic                   sd_in_valid,
    output logic [3:0]             sd_in,
    input  logic                   sd_out_valid,
    input  logic [3:0]             sd_out,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [3:0]             rsp_data,
    output logic                   rsp_last,
    output logic                   rsp_fail,
    output logic                   busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    if (NUM_REQ < 2 || TO_W < 2 || CELLS > 127 || ANS_LEN > 15) begin : g_bad_cfg
        $error("sd_job_sched: unsupported parameter set");
    end

    sd_state_e            r_state;
    logic [IW-1:0]        r_g;
    logic [IW-1:0]        r_ptr;
    logic [6:0]           r_cnt;
    logic                 r_started;
    logic                 r_perr;
    logic [3:0]           r_acnt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic                 r_sd_in_valid;
    logic [3:0]           r_sd_in;
    logic [NUM_REQ-1:0]   r_rsp_valid;
    logic [3:0]           r_rsp_data;
    logic                 r_rsp_last;
    logic                 r_rsp_fail;
`ifdef SD_SCHED_TIMEOUT_EN
    logic [TO_W-1:0]      r_to;
    logic                 w_to_fire;
`endif

    logic [NUM_REQ-1:0]   w_win;
    logic [IW-1:0]        w_idx;
    logic                 w_any;
    logic                 w_src_v;
    logic [3:0]           w_src_d;
    logic [NUM_REQ-1:0]   w_g_oh;
    logic                 w_first_fail;
    logic                 w_ans_last;

    sd_rr_arb #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    assign w_src_v      = src_valid[r_g];
    assign w_src_d      = src_data[{r_g, 2'b00} +: 4];
    assign w_g_oh       = NUM_REQ'(1) << r_g;
    // A fail code only means "unsolvable" as the first beat of a burst.
    assign w_first_fail = (r_acnt == 4'd0) && (sd_out == SD_FAIL_CODE);
    assign w_ans_last   = (r_acnt == 4'(ANS_LEN - 1));
`ifdef SD_SCHED_TIMEOUT_EN
    // Fires on the (2**TO_W-1)th empty WAIT cycle, when the counter saturates.
    assign w_to_fire    = (r_to == {{(TO_W-1){1'b1}}, 1'b0});
`endif

    // Job FSM: grant, cell forwarding, response routing; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_g           <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_started     <= 1'b0;
            r_perr        <= 1'b0;
            r_acnt        <= '0;
            r_gnt         <= '0;
            r_sd_in_valid <= 1'b0;
            r_sd_in       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_rsp_last    <= 1'b0;
            r_rsp_fail    <= 1'b0;
`ifdef SD_SCHED_TIMEOUT_EN
            r_to          <= '0;
`endif
        end else begin
            // Beat outputs are single-cycle pulses; idle value is zero.
            r_sd_in_valid <= 1'b0;
            r_sd_in       <= '0;
            r_rsp_valid   <= '0;
            r_rsp_data    <= '0;
            r_rsp_last    <= 1'b0;
            r_rsp_fail    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_g       <= w_idx;
                        r_gnt     <= w_win;
                        r_cnt     <= '0;
                        r_started <= 1'b0;
                        r_perr    <= 1'b0;
                        r_acnt    <= '0;
`ifdef SD_SCHED_TIMEOUT_EN
                        r_to      <= '0;
`endif
                        r_state   <= ST_FEED;
                    end
                end
                ST_FEED: begin
                    // Once the frame has started every cycle is a beat;
                    // bubbles are padded with 0 and mark the job as bad.
                    if (r_started || w_src_v) begin
                        r_started     <= 1'b1;
                        r_sd_in_valid <= 1'b1;
                        r_sd_in       <= w_src_v ? w_src_d : 4'd0;
                        if (!w_src_v) r_perr <= 1'b1;
                        r_cnt         <= r_cnt + 7'd1;
                        if (r_cnt == 7'(CELLS - 1)) begin
                            r_gnt   <= '0;
                            r_state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (sd_out_valid) begin
                        r_rsp_valid <= w_g_oh;
                        r_rsp_data  <= sd_out;
                        if (w_first_fail) begin
                            r_rsp_last <= 1'b1;
                            r_rsp_fail <= 1'b1;
                            r_ptr      <= r_g;
                            r_state    <= ST_IDLE;
                        end else begin
                            r_rsp_fail <= r_perr;
                            r_acnt     <= r_acnt + 4'd1;
                            if (w_ans_last) begin
                                r_rsp_last <= 1'b1;
                                r_ptr      <= r_g;
                                r_state    <= ST_IDLE;
                            end
                        end
                    end
`ifdef SD_SCHED_TIMEOUT_EN
                    else if (r_acnt == 4'd0) begin
                        r_to <= r_to + 1'b1;
                        if (w_to_fire) begin
                            r_rsp_valid <= w_g_oh;
                            r_rsp_data  <= SD_FAIL_CODE;
                            r_rsp_last  <= 1'b1;
                            r_rsp_fail  <= 1'b1;
                            r_state     <= ST_DRAIN;
                        end
                    end
`endif
                end
`ifdef SD_SCHED_TIMEOUT_EN
                ST_DRAIN: begin
                    // Absorb the late burst so it cannot leak into the next job.
                    if (sd_out_valid) begin
                        if (w_first_fail || w_ans_last) begin
                            r_ptr   <= r_g;
                            r_state <= ST_IDLE;
                        end else begin
                            r_acnt  <= r_acnt + 4'd1;
                        end
                    end
                end
`endif
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign sd_in_valid = r_sd_in_valid;
    assign sd_in       = r_sd_in;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_last    = r_rsp_last;
    assign rsp_fail    = r_rsp_fail;
    assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_sd_job_sched.sv
// Directed bench for sd_job_sched: single jobs, round-robin order, fail
// beat, padded frame, mid-job reset and (with SD_SCHED_TIMEOUT_EN) timeout.
module tb_sd_job_sched;

    localparam int N     = 2;
    localparam int CELLS = 81;
    localparam int ANS   = 15;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   src_valid;
    logic [4*N-1:0] src_data;
    logic           sd_in_valid;
    logic [3:0]     sd_in;
    logic           sd_out_valid;
    logic [3:0]     sd_out;
    logic [N-1:0]   rsp_valid;
    logic [3:0]     rsp_data;
    logic           rsp_last;
    logic           rsp_fail;
    logic           busy;

    int total = 0;
    int bad   = 0;

    // monitor state (written only by the monitor process)
    int n_in = 0, n_in_bad = 0, n_zero = 0, n_rsp = 0, n_multi = 0;
    logic [N-1:0] m_v [256];
    logic [3:0]   m_d [256];
    logic         m_l [256];
    logic         m_f [256];
    // expected solver-side cells, written by the stimulus
    logic [3:0]   exp_in [1024];

    sd_job_sched #(.NUM_REQ(N), .CELLS(CELLS), .ANS_LEN(ANS), .TO_W(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .gnt          (gnt),
        .src_valid    (src_valid),
        .src_data     (src_data),
        .sd_in_valid  (sd_in_valid),
        .sd_in        (sd_in),
        .sd_out_valid (sd_out_valid),
        .sd_out       (sd_out),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .rsp_last     (rsp_last),
        .rsp_fail     (rsp_fail),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(gnt) > 1) n_multi++;
        if (sd_in_valid) begin
            if (sd_in !== exp_in[n_in % 1024]) n_in_bad++;
            if (sd_in == 4'd0) n_zero++;
            n_in++;
        end
        if (rsp_valid != '0) begin
            if (n_rsp < 256) begin
                m_v[n_rsp] = rsp_valid;
                m_d[n_rsp] = rsp_data;
                m_l[n_rsp] = rsp_last;
                m_f[n_rsp] = rsp_fail;
            end
            n_rsp++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] cell_val(input int i);
        return 4'((i % 9) + 1);
    endfunction

    function automatic logic [3:0] ans_val(input int k, input int g);
        return 4'(((k * 7 + g) % 9) + 1);
    endfunction

    task automatic wait_gnt(input int g);
        for (int i = 0; i < 8; i++) begin
            if (gnt != '0) break;
            tick();
        end
        chk("gnt_idx", 32'(gnt), 32'(1 << g));
    endtask

    // Drive n cells from source g; non-granted sources also show garbage.
    task automatic stream_cells(input int g, input int n, input bit pad);
        int b;
        b = n_in;
        for (int i = 0; i < n; i++) begin
            src_data = '1;
            if (pad && i >= 40 && i <= 42) begin
                src_valid = ~N'(1 << g);
                exp_in[(b + i) % 1024] = 4'd0;
            end else begin
                src_valid = '1;
                src_data[4*g +: 4] = cell_val(i);
                exp_in[(b + i) % 1024] = cell_val(i);
            end
            tick();
        end
        src_valid = '0;
        src_data  = '0;
    endtask

    task automatic run_job(input int g, input bit pad, input bit fail, input logic [N-1:0] req_after);
        int b_in, b_bad, b_zero, b_rsp, nb;
        bit fexp;
        wait_gnt(g);
        req    = req_after;
        b_in   = n_in;
        b_bad  = n_in_bad;
        b_zero = n_zero;
        b_rsp  = n_rsp;
        stream_cells(g, CELLS, pad);
        chk("gnt_drop", 32'(gnt), 32'd0);
        chk("busy_wait", 32'(busy), 32'd1);
        tick();
        chk("in_beats", 32'(n_in - b_in), 32'(CELLS));
        chk("in_data_bad", 32'(n_in_bad - b_bad), 32'd0);
        chk("in_zero", 32'(n_zero - b_zero), pad ? 32'd3 : 32'd0);
        sd_out_valid = 1'b1;
        if (fail) begin
            sd_out = 4'd10;
            tick();
        end else begin
            for (int k = 0; k < ANS; k++) begin
                sd_out = ans_val(k, g);
                tick();
            end
        end
        sd_out_valid = 1'b0;
        sd_out       = '0;
        chk("last_vis", 32'(rsp_last), 32'd1);
        chk("idle_after", 32'(busy), 32'd0);
        tick();
        nb   = fail ? 1 : ANS;
        fexp = fail | pad;
        chk("rsp_beats", 32'(n_rsp - b_rsp), 32'(nb));
        for (int k = 0; k < nb; k++) begin
            chk("rsp_valid", 32'(m_v[(b_rsp + k) % 256]), 32'(1 << g));
            chk("rsp_data", 32'(m_d[(b_rsp + k) % 256]), fail ? 32'd10 : 32'(ans_val(k, g)));
            chk("rsp_last", 32'(m_l[(b_rsp + k) % 256]), (k == nb - 1) ? 32'd1 : 32'd0);
            chk("rsp_fail", 32'(m_f[(b_rsp + k) % 256]), fexp ? 32'd1 : 32'd0);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"},   32'(gnt), 32'd0);
        chk({tag, "_sdv"},   32'(sd_in_valid), 32'd0);
        chk({tag, "_sdin"},  32'(sd_in), 32'd0);
        chk({tag, "_rspv"},  32'(rsp_valid), 32'd0);
        chk({tag, "_rspd"},  32'(rsp_data), 32'd0);
        chk({tag, "_rspl"},  32'(rsp_last), 32'd0);
        chk({tag, "_rspf"},  32'(rsp_fail), 32'd0);
        chk({tag, "_busy"},  32'(busy), 32'd0);
    endtask

    initial begin
        int b;
        rst_n = 1'b0; req = '0; src_valid = '0; src_data = '0;
        sd_out_valid = 1'b0; sd_out = '0;
        for (int i = 0; i < 1024; i++) exp_in[i] = 4'd0;
        tick(); tick();
        chk_all_zero("reset");
        rst_n = 1'b1;
        tick();

        // solver chatter while idle must never reach a source
        b = n_rsp;
        sd_out_valid = 1'b1; sd_out = 4'd5;
        tick(); tick(); tick();
        sd_out_valid = 1'b0; sd_out = '0;
        tick();
        chk("idle_chatter", 32'(n_rsp - b), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        // single job from source 0
        req = 2'b01;
        run_job(0, 1'b0, 1'b0, 2'b00);

        // both sources held: strict rotation 1,0,1,0
        req = 2'b11;
        run_job(1, 1'b0, 1'b0, 2'b11);
        run_job(0, 1'b0, 1'b0, 2'b11);
        run_job(1, 1'b0, 1'b0, 2'b11);
        run_job(0, 1'b0, 1'b0, 2'b00);

        // unsolvable puzzle: single fail beat
        req = 2'b01;
        run_job(0, 1'b0, 1'b1, 2'b00);

        // source 1 with three bubbles at cells 40-42
        req = 2'b10;
        run_job(1, 1'b1, 1'b0, 2'b00);

        // reset in the middle of a frame (pointer was 1 before)
        req = 2'b01;
        wait_gnt(0);
        req = 2'b00;
        stream_cells(0, 30, 1'b0);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("midrst");
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);
        chk("post_rst_gnt", 32'(gnt), 32'd0);
        req = 2'b11;
        run_job(1, 1'b0, 1'b0, 2'b00);

`ifdef SD_SCHED_TIMEOUT_EN
        // solver never answers: timeout fail beat, late burst swallowed
        req = 2'b01;
        wait_gnt(0);
        req = 2'b00;
        stream_cells(0, CELLS, 1'b0);
        b = n_rsp;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid != '0) break;
            tick();
        end
        chk("to_valid", 32'(rsp_valid), 32'd1);
        chk("to_data", 32'(rsp_data), 32'd10);
        chk("to_fail", 32'(rsp_fail), 32'd1);
        chk("to_last", 32'(rsp_last), 32'd1);
        chk("to_drain_busy", 32'(busy), 32'd1);
        tick();
        sd_out_valid = 1'b1;
        for (int k = 0; k < ANS; k++) begin
            sd_out = ans_val(k, 0);
            tick();
        end
        sd_out_valid = 1'b0; sd_out = '0;
        tick();
        chk("to_swallow", 32'(n_rsp - b), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        req = 2'b01;
        run_job(0, 1'b0, 1'b0, 2'b00);
`endif

        chk("gnt_onehot", 32'(n_multi), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
